// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: register enables, flush/bubble strobes, PC enable, valid tracking,
// data-memory wait FSM and sticky halt. Define PIPE_CTRL_PERF_EN to build the performance counters.
module pipe_ctrl #(
    parameter int NREG     = 4,
    parameter int MEM_REG  = 2,
    parameter int LU_REG   = 0,
    parameter int HALT_REG = 2,
    parameter int CNT_W    = 32,
    localparam int IW      = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_req,
    input  logic             lu_hazard,
    input  logic             flush_req,
    input  logic [IW-1:0]    flush_src,
    input  logic             halt_in,
    output logic             pc_en,
    output logic [NREG-1:0]  en,
    output logic [NREG-1:0]  flush,
    output logic [NREG-1:0]  bubble,
    output logic [NREG-1:0]  valid,
    output logic             mem_clr,
    output logic             stall,
    output logic             halt,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            memop;
    logic            halt_go;
    logic            stall_raw;
    logic            advance;
    logic            hold;
    logic [NREG-1:0] valid_next;
    logic [NREG:0]   shift_in;
    int              src_i;

    // Saturating increment used by the performance counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value, input logic inc);
        logic [CNT_W-1:0] result;
        if (inc && (value != {CNT_W{1'b1}})) begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            result = value;
        end
        return result;
    endfunction

    assign memop    = mem_req & valid[MEM_REG];
    assign halt_go  = halt_in & valid[HALT_REG];
    assign shift_in = {valid, 1'b1};

    // State register; reset always lands in RUN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and raw memory stall; halt takes priority over any memory wait.
    always_comb begin
        state_next = state;
        stall_raw  = 1'b0;
        case (state)
            RUN: begin
                stall_raw = memop & ~dhit;
                if (halt_go) begin
                    state_next = HALTED;
                end else if (memop && !dhit) begin
                    state_next = MEMWAIT;
                end else begin
                    state_next = RUN;
                end
            end
            MEMWAIT: begin
                stall_raw = ~dhit;
                if (halt_go) begin
                    state_next = HALTED;
                end else if (dhit) begin
                    state_next = RUN;
                end else begin
                    state_next = MEMWAIT;
                end
            end
            HALTED: begin
                stall_raw  = 1'b0;
                state_next = HALTED;
            end
            default: begin
                stall_raw  = 1'b0;
                state_next = RUN;
            end
        endcase
    end

    // Strobe generation; every strobe is forced low while reset is held.
    always_comb begin
        stall   = stall_raw & ~RST;
        mem_clr = dhit & (memop | (state == MEMWAIT)) & ~RST;
        advance = ihit & ~stall_raw & (state != HALTED) & ~RST;
        hold    = lu_hazard & ~flush_req;
        pc_en   = advance & ~hold;
        src_i   = {{(32-IW){1'b0}}, flush_src};
        if (src_i > NREG - 1) begin
            src_i = NREG - 1;
        end else begin
            src_i = src_i;
        end
        en     = {NREG{1'b0}};
        flush  = {NREG{1'b0}};
        bubble = {NREG{1'b0}};
        for (int k = 0; k < NREG; k++) begin
            if (k <= LU_REG) begin
                en[k] = advance & ~hold;
            end else begin
                en[k] = advance;
            end
            flush[k]  = advance & flush_req & (k <= src_i);
            bubble[k] = advance & hold & (k == LU_REG + 1);
        end
    end

    // Valid bits shift forward with each enabled register; flushed or bubbled slots go empty.
    always_comb begin
        valid_next = valid;
        for (int k = 0; k < NREG; k++) begin
            if (!en[k]) begin
                valid_next[k] = valid[k];
            end else if (flush[k] || bubble[k]) begin
                valid_next[k] = 1'b0;
            end else begin
                valid_next[k] = shift_in[k];
            end
        end
    end

    // Valid register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= {NREG{1'b0}};
        end else begin
            valid <= valid_next;
        end
    end

    assign halt = (state == HALTED);

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Saturating event counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cyc_q   <= {CNT_W{1'b0}};
            stall_q <= {CNT_W{1'b0}};
            flush_q <= {CNT_W{1'b0}};
        end else begin
            cyc_q   <= sat_inc(cyc_q, state != HALTED);
            stall_q <= sat_inc(stall_q, stall);
            flush_q <= sat_inc(flush_q, advance & flush_req);
        end
    end

    assign cyc_cnt   = cyc_q;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign cyc_cnt   = {CNT_W{1'b0}};
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expectations are queued with each stimulus cycle and
// compared on the falling edge that follows; registered results are queued one cycle later.
module tb_pipe_ctrl;

    localparam int NREG  = 4;
    localparam int CNT_W = 4;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RST;
    logic             ihit, dhit, mem_req, lu_hazard, flush_req, halt_in;
    logic [1:0]       flush_src;
    logic             pc_en, mem_clr, stall, halt;
    logic [NREG-1:0]  en, flush, bubble, valid;
    logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t  sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
        .lu_hazard(lu_hazard), .flush_req(flush_req), .flush_src(flush_src),
        .halt_in(halt_in), .pc_en(pc_en), .en(en), .flush(flush), .bubble(bubble),
        .valid(valid), .mem_clr(mem_clr), .stall(stall), .halt(halt),
        .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0h, expected %0h", phase, tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input string tag);
        if (tag == "pc_en")        return {31'd0, pc_en};
        else if (tag == "en")      return {28'd0, en};
        else if (tag == "flush")   return {28'd0, flush};
        else if (tag == "bubble")  return {28'd0, bubble};
        else if (tag == "valid")   return {28'd0, valid};
        else if (tag == "mem_clr") return {31'd0, mem_clr};
        else if (tag == "stall")   return {31'd0, stall};
        else if (tag == "halt")    return {31'd0, halt};
        else if (tag == "cyc")     return {28'd0, cyc_cnt};
        else if (tag == "stl")     return {28'd0, stall_cnt};
        else if (tag == "fls")     return {28'd0, flush_cnt};
        else                       return 32'hxxxx_xxxx;
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic exp_comb(input logic pc, input logic [3:0] e, input logic [3:0] fl,
                            input logic [3:0] bu, input logic st, input logic mc);
        push("pc_en", {31'd0, pc});
        push("en", {28'd0, e});
        push("flush", {28'd0, fl});
        push("bubble", {28'd0, bu});
        push("stall", {31'd0, st});
        push("mem_clr", {31'd0, mc});
    endtask

    task automatic tick();
        exp_t e;
        @(negedge CLK);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.tag), e.exp);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic ih, input logic dh, input logic mr, input logic lu,
                          input logic fr, input logic [1:0] fs, input logic hi);
        ihit = ih; dhit = dh; mem_req = mr; lu_hazard = lu;
        flush_req = fr; flush_src = fs; halt_in = hi;
    endtask

    task automatic push_cnt(input logic [3:0] c, input logic [3:0] s, input logic [3:0] f);
        push("cyc", PERF ? {28'd0, c} : 32'd0);
        push("stl", PERF ? {28'd0, s} : 32'd0);
        push("fls", PERF ? {28'd0, f} : 32'd0);
    endtask

    logic [3:0] fill_v [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

    initial begin
        RST = 1'b1;
        set_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1);
        phase = "reset";
        exp_comb(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        push("valid", 32'd0);
        push("halt", 32'd0);
        push_cnt(4'd0, 4'd0, 4'd0);
        tick();
        RST = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);

        phase = "fill";
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
            if (i > 0) push("valid", {28'd0, fill_v[i-1]});
            exp_comb(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
            tick();
        end

        phase = "memmiss";
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        push("valid", 32'hf);
        for (int i = 0; i < 3; i++) begin
            exp_comb(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
            tick();
        end
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        exp_comb(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        push("valid", 32'hf);
        push("stl", PERF ? 32'd3 : 32'd0);
        exp_comb(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();

        phase = "memhit";
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        exp_comb(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        exp_comb(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
        push("stl", PERF ? 32'd3 : 32'd0);
        tick();

        phase = "loaduse";
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        exp_comb(1'b0, 4'b1110, 4'b0000, 4'b0010, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        push("valid", 32'b1101);
        exp_comb(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();

        phase = "flush";
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        push("valid", 32'b1011);
        exp_comb(1'b1, 4'b1111, 4'b0011, 4'b0000, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        push("valid", 32'b0100);
        exp_comb(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        push("valid", 32'b0100);
        exp_comb(1'b1, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0);
        tick();

        phase = "refill";
        push("fls", PERF ? 32'd2 : 32'd0);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
            push("valid", (i == 0) ? 32'd0 : {28'd0, fill_v[i-1]});
            exp_comb(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
            tick();
        end

        phase = "halt";
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
        push("valid", 32'b0111);
        push("halt", 32'd0);
        exp_comb(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 12; i++) begin
            set_in(1'b1, 1'b0, (i >= 10), i[0], 1'b0, 2'd0, 1'b0);
            push("halt", 32'd1);
            push("valid", 32'hf);
            exp_comb(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
            tick();
        end
        RST = 1'b1;
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        push("halt", 32'd0);
        push("valid", 32'd0);
        exp_comb(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        tick();
        RST = 1'b0;

        phase = "rst_memwait";
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
            tick();
        end
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        push("valid", 32'b0111);
        exp_comb(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
        tick();
        set_in(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        push("stall", 32'd1);
        tick();
        RST = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        push("valid", 32'd0);
        push("stall", 32'd0);
        tick();
        RST = 1'b0;
        push("valid", 32'd0);
        push("stall", 32'd0);
        tick();

        phase = "saturate";
        RST = 1'b1;
        tick();
        RST = 1'b0;
        for (int i = 0; i < 22; i++) begin
            if (i == 10) push("cyc", PERF ? 32'd10 : 32'd0);
            tick();
        end
        push_cnt(4'd15, 4'd0, 4'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
